lmdpl_dual_rail_decoder: RTL

- Receiving end of the LMDPL interface: consumes the mask share (x1) and dual-rail masked share (x2/x2_bar) produced by LMDPL gadgets.
- Sequences the precharge/evaluate phases and checks the dual-rail code.
- Converts back to a two-share Boolean-masked word (share0 = mask, share1 = masked value), registered, with a valid strobe.
- Never combines the two shares; the unmasked value exists nowhere in the block.

---
 rtl/lmdpl_pkg.sv | 27 ++
 rtl/lmdpl_rail_checker.sv | 31 +++
 rtl/lmdpl_dual_rail_decoder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lmdpl_pkg.sv
// Shared definitions for the LMDPL dual-rail receive path: FSM states,
// dual-rail code points ({x2, x2_bar}) and a counter-width helper.
package lmdpl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRECHARGE = 2'd1,
    EVALUATE  = 2'd2,
    DONE      = 2'd3
  } state_e;

  // Dual-rail code points, written as {x2, x2_bar}
  localparam logic [1:0] DR_NULL    = 2'b00;
  localparam logic [1:0] DR_ZERO    = 2'b01;
  localparam logic [1:0] DR_ONE     = 2'b10;
  localparam logic [1:0] DR_INVALID = 2'b11;

  // Bits needed to hold values 0..n-1; never less than 1 so a counter
  // for n=1 still has a legal declaration.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/lmdpl_rail_checker.sv
// Combinational reduction of WIDTH dual-rail pairs into three flags:
// every pair at NULL, every pair carrying a valid 0/1 code, any pair at 11.
module lmdpl_rail_checker
  import lmdpl_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x2_bar,
  output logic             all_null,
  output logic             all_complete,
  output logic             any_invalid
);

  logic [1:0] code;

  // Per-bit classification folded into the three reduction flags
  always_comb begin
    all_null     = 1'b1;
    all_complete = 1'b1;
    any_invalid  = 1'b0;
    code         = DR_NULL;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      code = {x2[i], x2_bar[i]};
      if (code != DR_NULL)                      all_null     = 1'b0;
      if (code != DR_ZERO && code != DR_ONE)    all_complete = 1'b0;
      if (code == DR_INVALID)                   any_invalid  = 1'b1;
    end
  end

endmodule

// File: rtl/lmdpl_dual_rail_decoder.sv
// LMDPL receive-side decoder: sequences precharge/evaluate, checks the
// dual-rail code and registers the two Boolean shares (mask, masked value)
// without ever combining them.
// Optional build macro LMDPL_EARLY_FAULT_EN: flag a 11 code in EVALUATE
// immediately instead of letting it run into the timeout.
module lmdpl_dual_rail_decoder
  import lmdpl_pkg::*;
#(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned PRE_CYCLES = 1,
  parameter int unsigned TIMEOUT    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x2_bar,
  output logic             precharge,
  output logic             busy,
  output logic [WIDTH-1:0] share0,
  output logic [WIDTH-1:0] share1,
  output logic             valid,
  output logic             fault
);

  localparam int unsigned PW = clog2(PRE_CYCLES);
  localparam int unsigned EW = clog2(TIMEOUT);

  state_e           state_q, state_d;
  logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
  logic [EW-1:0]    eval_cnt_q, eval_cnt_d;
  logic [WIDTH-1:0] share0_q, share1_q;
  logic             fault_q;
  logic             capture, fault_set;
  logic             all_null, all_complete, any_invalid;
  logic             early_fault;

  lmdpl_rail_checker #(
    .WIDTH(WIDTH)
  ) u_checker (
    .x2          (x2),
    .x2_bar      (x2_bar),
    .all_null    (all_null),
    .all_complete(all_complete),
    .any_invalid (any_invalid)
  );

`ifdef LMDPL_EARLY_FAULT_EN
  assign early_fault = any_invalid;
`else
  logic unused_invalid;
  assign unused_invalid = any_invalid;
  assign early_fault    = 1'b0;
`endif

  // State and phase counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      eval_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      eval_cnt_q <= eval_cnt_d;
    end
  end

  // Share capture and sticky fault
  always_ff @(posedge clk) begin
    if (rst) begin
      share0_q <= '0;
      share1_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (capture) begin
        share0_q <= x1;
        share1_q <= x2;
      end
      if (fault_set) fault_q <= 1'b1;
    end
  end

  // Next-state, counter updates and capture/fault decisions
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    eval_cnt_d = eval_cnt_q;
    capture    = 1'b0;
    fault_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = PRECHARGE;
          pre_cnt_d = PW'(PRE_CYCLES - 1);
        end
      end
      PRECHARGE: begin
        if (pre_cnt_q != '0) begin
          pre_cnt_d = pre_cnt_q - PW'(1);
        end else if (all_null) begin
          state_d    = EVALUATE;
          eval_cnt_d = '0;
        end else begin
          fault_set = 1'b1;
          state_d   = IDLE;
        end
      end
      EVALUATE: begin
        if (early_fault) begin
          fault_set  = 1'b1;
          state_d    = IDLE;
          eval_cnt_d = '0;
        end else if (all_complete) begin
          capture    = 1'b1;
          state_d    = DONE;
          eval_cnt_d = '0;
        end else if (eval_cnt_q == EW'(TIMEOUT - 1)) begin
          fault_set  = 1'b1;
          state_d    = IDLE;
          eval_cnt_d = '0;
        end else begin
          eval_cnt_d = eval_cnt_q + EW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    precharge = 1'b1;
    busy      = 1'b1;
    valid     = 1'b0;
    case (state_q)
      IDLE:     busy      = 1'b0;
      EVALUATE: precharge = 1'b0;
      DONE:     valid     = 1'b1;
      default:  ;
    endcase
  end

  assign share0 = share0_q;
  assign share1 = share1_q;
  assign fault  = fault_q;

endmodule
